// File: rtl/bp_types.sv
// Shared types for the branch predictor: control-flow kinds, BTB entry layout
// and the 2-bit saturating direction counter helper.
package bp_types;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JAL  = 2'd1,
    JALR = 2'd2,
    RET  = 2'd3
  } bp_kind_t;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Widest tag any legal IDX_LSB/IDX_BITS combination can produce; narrower
  // tags are stored zero-extended.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:2]          target;
    bp_kind_t             kind;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST) ? ST : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Non-speculative return address stack: circular buffer with a top pointer
// and an occupancy count that saturates at RAS_DEPTH (oldest entry is lost).
module bp_ras #(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [PW:0]   C_ONE = 1;
  localparam logic [PW:0]   FULL  = (PW + 1)'(RAS_DEPTH);

  logic [31:0]   mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q;    // next free slot; top lives at ptr_q-1
  logic [PW:0]   count_q;
  logic [PW-1:0] top_idx;

  assign top_idx = ptr_q - P_ONE;
  assign empty   = (count_q == '0);
  assign top     = empty ? 32'h0 : mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (pop && push && !empty) begin
      // Return through a linking register: replace the top in place.
      mem_q[top_idx] <= push_data;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_q + P_ONE;
      if (count_q != FULL) count_q <= count_q + C_ONE;
    end else if (pop && !empty) begin
      ptr_q   <= top_idx;
      count_q <= count_q - C_ONE;
    end
  end

endmodule

// File: rtl/bp_unit.sv
// Set-associative BTB with 2-bit direction counters, per-set LRU and a RAS.
// IF looks up combinationally; EX updates on the clock edge.
module bp_unit
  import bp_types::*;
#(
  parameter int         IDX_BITS  = 6,
  parameter int         IDX_LSB   = 2,
  parameter int         WAYS      = 2,
  parameter int         RAS_DEPTH = 8,
  parameter logic [1:0] CTR_INIT  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  bp_kind_t    ex_kind,
  input  logic        ex_link,
  input  logic        ex_taken,
  input  logic [31:0] ex_target
);

  localparam int SETS    = 1 << IDX_BITS;
  localparam int TAG_LSB = IDX_LSB + IDX_BITS;

  function automatic logic [IDX_BITS-1:0] idx_of(input logic [31:0] pc);
    return pc[IDX_LSB +: IDX_BITS];
  endfunction

  function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
    return TAG_MAX_W'(pc >> TAG_LSB);
  endfunction

  btb_entry_t btb_q [WAYS][SETS];

  logic [IDX_BITS-1:0]  if_idx, ex_idx;
  logic [TAG_MAX_W-1:0] if_tag, ex_tag;
  logic [WAYS-1:0]      if_hit_w, ex_hit_w;
  btb_entry_t           if_ent, ex_ent;
  logic                 ex_hit, ex_hit_way, victim, way_sel, lru_cur;
  logic                 upd_en;
  logic                 ras_push, ras_pop, ras_empty;
  logic [31:0]          ras_top;

  assign if_idx = idx_of(if_pc);
  assign if_tag = tag_of(if_pc);
  assign ex_idx = idx_of(ex_pc);
  assign ex_tag = tag_of(ex_pc);

  // ex_valid is a plain qualifier (no ready): the update is taken on every
  // edge where ex_valid & ~stall, with rst overriding everything.
  assign upd_en = ex_valid && !stall;

  always_comb begin
    if_hit_w = '0;
    if_ent   = '0;
    ex_hit_w = '0;
    ex_ent   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if_hit_w[w] = btb_q[w][if_idx].valid && (btb_q[w][if_idx].tag == if_tag);
      ex_hit_w[w] = btb_q[w][ex_idx].valid && (btb_q[w][ex_idx].tag == ex_tag);
      if (if_hit_w[w]) if_ent = btb_q[w][if_idx];
      if (ex_hit_w[w]) ex_ent = btb_q[w][ex_idx];
    end
  end

  assign pred_hit   = |if_hit_w;
  assign pred_taken = pred_hit && ((if_ent.kind != BR) || if_ent.ctr[1]);

  always_comb begin
    pred_target = 32'h0;
    if (pred_taken) begin
      if (if_ent.kind == RET && !ras_empty) pred_target = {ras_top[31:2], 2'b00};
      else                                  pred_target = {if_ent.target, 2'b00};
    end
  end

  assign ex_hit     = |ex_hit_w;
  assign ex_hit_way = (WAYS > 1) ? ex_hit_w[WAYS-1] : 1'b0;

  always_comb begin
    victim = 1'b0;
    if (WAYS > 1) begin
      if (!btb_q[0][ex_idx].valid)           victim = 1'b0;
      else if (!btb_q[WAYS-1][ex_idx].valid) victim = 1'b1;
      else                                   victim = lru_cur;
    end
  end

  assign way_sel = ex_hit ? ex_hit_way : victim;

  // LRU bit per set names the way to replace next.
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;
    always_ff @(posedge clk) begin
      if (rst) lru_q <= '0;
      else if (upd_en && (ex_hit || ex_taken)) lru_q[ex_idx] <= ~way_sel;
    end
    assign lru_cur = lru_q[ex_idx];
  end else begin : g_no_lru
    assign lru_cur = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          btb_q[w][s].valid <= 1'b0;
    end else if (upd_en) begin
      if (ex_hit) begin
        btb_q[way_sel][ex_idx].ctr <= ctr_next(ex_ent.ctr, ex_taken);
        if (ex_taken) begin
          btb_q[way_sel][ex_idx].target <= ex_target[31:2];
          btb_q[way_sel][ex_idx].kind   <= ex_kind;
        end
      end else if (ex_taken) begin
        btb_q[way_sel][ex_idx] <= '{valid:  1'b1,
                                    tag:    ex_tag,
                                    target: ex_target[31:2],
                                    kind:   ex_kind,
                                    ctr:    CTR_INIT};
      end
    end
  end

  assign ras_push = upd_en && ex_link && (ex_kind != BR);
  assign ras_pop  = upd_en && (ex_kind == RET);

  bp_ras #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(ex_pc + 32'd4),
    .top      (ras_top),
    .empty    (ras_empty)
  );

  logic unused_bits;
  assign unused_bits = ^{ex_target[1:0], ras_top[1:0]};

endmodule

// File: tb/tb_bp_unit.sv
// Directed bench for bp_unit: drivers push expected lookup results into a
// scoreboard queue, a negedge monitor pops and compares against the outputs.
module tb_bp_unit;
  import bp_types::*;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  bp_kind_t    ex_kind;
  logic        ex_link, ex_taken;
  logic [31:0] ex_target;

  always #5 clk = ~clk;

  bp_unit #(
    .IDX_BITS(6), .IDX_LSB(2), .WAYS(2), .RAS_DEPTH(8), .CTR_INIT(2'b10)
  ) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_kind(ex_kind), .ex_link(ex_link),
    .ex_taken(ex_taken), .ex_target(ex_target)
  );

  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];
  string       name_q[$];
  logic        look_req = 1'b0;
  logic [33:0] mon_exp;
  string       mon_name;

  task automatic check_pred(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
               nm, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic ras_count(input string nm, input int exp);
    checks++;
    if (int'(u_dut.u_ras.count_q) != exp) begin
      errors++;
      $display("FAIL %s: ras count got %0d, want %0d", nm, u_dut.u_ras.count_q, exp);
    end
  endtask

  // Monitor: every presented lookup is matched against the scoreboard head.
  always @(negedge clk) begin
    if (look_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: lookup with empty scoreboard");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check_pred(mon_name, {pred_hit, pred_taken, pred_target}, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bp_kind_t k, input logic [31:0] pc, input logic link,
                        input logic tk, input logic [31:0] tgt);
    ex_valid  = 1'b1;
    ex_kind   = k;
    ex_pc     = pc;
    ex_link   = link;
    ex_taken  = tk;
    ex_target = tgt;
  endtask

  task automatic set_look(input string nm, input logic [31:0] pc, input logic h,
                          input logic t, input logic [31:0] tgt);
    if_pc = pc;
    exp_q.push_back({h, t, tgt});
    name_q.push_back(nm);
    look_req = 1'b1;
  endtask

  task automatic report(input bp_kind_t k, input logic [31:0] pc, input logic link,
                        input logic tk, input logic [31:0] tgt);
    set_ex(k, pc, link, tk, tgt);
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic h,
                        input logic t, input logic [31:0] tgt);
    set_look(nm, pc, h, t, tgt);
    tick();
    look_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; if_pc = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_kind = BR; ex_link = 1'b0; ex_taken = 1'b0; ex_target = '0;
    repeat (2) tick();
    rst = 1'b0;

    lookup("reset_miss", 32'h60, 1'b0, 1'b0, 32'h0);
    ras_count("reset_ras", 0);

    // Direction counter walk on BR@0x80.
    report(BR, 32'h80, 1'b0, 1'b1, 32'h40);
    lookup("br_alloc", 32'h80, 1'b1, 1'b1, 32'h40);
    report(BR, 32'h80, 1'b0, 1'b0, 32'h84);
    lookup("br_nt1", 32'h80, 1'b1, 1'b0, 32'h0);
    report(BR, 32'h80, 1'b0, 1'b0, 32'h84);
    lookup("br_nt2", 32'h80, 1'b1, 1'b0, 32'h0);
    report(BR, 32'h80, 1'b0, 1'b0, 32'h84);
    report(BR, 32'h80, 1'b0, 1'b1, 32'h40);
    lookup("br_floor_t1", 32'h80, 1'b1, 1'b0, 32'h0);
    report(BR, 32'h80, 1'b0, 1'b1, 32'h40);
    lookup("br_t2", 32'h80, 1'b1, 1'b1, 32'h40);
    report(BR, 32'h80, 1'b0, 1'b1, 32'h40);
    report(BR, 32'h80, 1'b0, 1'b1, 32'h40);
    report(BR, 32'h80, 1'b0, 1'b0, 32'h84);
    lookup("br_sat", 32'h80, 1'b1, 1'b1, 32'h40);

    // Set 0: two ways, then LRU eviction.
    report(BR, 32'h100, 1'b0, 1'b1, 32'h500);
    report(BR, 32'h200, 1'b0, 1'b1, 32'h600);
    lookup("way_a", 32'h100, 1'b1, 1'b1, 32'h500);
    lookup("way_b", 32'h200, 1'b1, 1'b1, 32'h600);
    report(BR, 32'h100, 1'b0, 1'b1, 32'h500);
    report(BR, 32'h300, 1'b0, 1'b1, 32'h700);
    lookup("lru_keep", 32'h100, 1'b1, 1'b1, 32'h500);
    lookup("lru_evict", 32'h200, 1'b0, 1'b0, 32'h0);
    lookup("lru_new", 32'h300, 1'b1, 1'b1, 32'h700);

    // Calls and returns.
    report(JAL, 32'h1010, 1'b1, 1'b1, 32'h3000);
    ras_count("push1", 1);
    lookup("jal_btb", 32'h1010, 1'b1, 1'b1, 32'h3000);
    report(RET, 32'h2020, 1'b0, 1'b1, 32'h1014);
    ras_count("pop1", 0);
    lookup("ret_empty", 32'h2020, 1'b1, 1'b1, 32'h1014);
    report(JALR, 32'h1840, 1'b1, 1'b1, 32'h5000);
    lookup("ret_ras", 32'h2020, 1'b1, 1'b1, 32'h1844);
    report(RET, 32'h2020, 1'b0, 1'b1, 32'h1844);
    report(RET, 32'h2020, 1'b0, 1'b1, 32'h1844);
    ras_count("pop_empty", 0);
    lookup("ret_after_empty", 32'h2020, 1'b1, 1'b1, 32'h1844);
    report(JAL, 32'h1010, 1'b1, 1'b1, 32'h3000);
    report(RET, 32'h2600, 1'b1, 1'b1, 32'h1014);
    ras_count("pop_push", 1);
    lookup("ret_pop_push", 32'h2020, 1'b1, 1'b1, 32'h2604);
    report(RET, 32'h2020, 1'b0, 1'b1, 32'h2220);
    ras_count("pop_push_drain", 0);

    // Overflow: nine pushes into eight slots, first value lost.
    for (int i = 0; i < 9; i++)
      report(JAL, 32'h4000 + 32'h100 * i, 1'b1, 1'b1, 32'h8000);
    ras_count("ras_full", 8);
    for (int k = 0; k < 8; k++) begin
      lookup($sformatf("ras_pop%0d", k), 32'h2020, 1'b1, 1'b1, 32'h4004 + 32'h100 * (8 - k));
      report(RET, 32'h2020, 1'b0, 1'b1, 32'h2220);
    end
    ras_count("ras_drained", 0);
    lookup("ras_oldest_lost", 32'h2020, 1'b1, 1'b1, 32'h2220);

    // Stall freezes all state but lookup still follows if_pc.
    stall = 1'b1;
    report(BR, 32'h80, 1'b0, 1'b0, 32'h84);
    report(BR, 32'h80, 1'b0, 1'b0, 32'h84);
    report(BR, 32'h3c0, 1'b0, 1'b1, 32'h900);
    report(JAL, 32'h1010, 1'b1, 1'b1, 32'h3000);
    lookup("stall_hit", 32'h80, 1'b1, 1'b1, 32'h40);
    lookup("stall_miss", 32'h3c0, 1'b0, 1'b0, 32'h0);
    ras_count("stall_ras", 0);
    stall = 1'b0;

    // Reset wins over a concurrent update.
    rst = 1'b1;
    report(BR, 32'h3c0, 1'b0, 1'b1, 32'h900);
    rst = 1'b0;
    lookup("rst_nowrite", 32'h3c0, 1'b0, 1'b0, 32'h0);
    lookup("rst_clear", 32'h80, 1'b0, 1'b0, 32'h0);

    // Allocation is invisible to a same-cycle lookup.
    set_ex(BR, 32'h3c0, 1'b0, 1'b1, 32'h900);
    set_look("same_cycle", 32'h3c0, 1'b0, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    look_req = 1'b0;
    lookup("same_next", 32'h3c0, 1'b1, 1'b1, 32'h900);

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected lookups never observed", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
